// File: rtl/y86_pkg.sv
// Shared Y86-64 front-end definitions: byte type, fetch-side sizes and
// the prefetch FSM state encoding.
package y86_pkg;

  localparam int unsigned WORD_BYTES      = 8;
  localparam int unsigned MAX_INSTR_BYTES = 10;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP,
    ERR
  } pf_state_t;

endpackage

// File: rtl/imem_prefetch_if.sv
// Instruction-memory read bus between the prefetch queue (master) and
// instruction memory (slave). One outstanding request at a time.
interface imem_prefetch_if
  import y86_pkg::*;
#(
  parameter int unsigned ADDR_W = 64
);

  logic                      mem_req;
  logic [ADDR_W-1:0]         mem_addr;
  logic                      mem_ack;
  logic [WORD_BYTES*8-1:0]   mem_rdata;
  logic                      mem_err;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata,
    input  mem_err
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata,
    output mem_err
  );

endinterface

// File: rtl/pf_byte_ring.sv
// Byte-wide circular storage for the prefetch queue. Writes up to one
// memory word per cycle (skipping a leading offset); reads a wrapping
// instruction-sized window combinationally.
module pf_byte_ring
  import y86_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               wr_en_i,
  input  logic [$clog2(DEPTH_BYTES)-1:0]     wr_ptr_i,
  input  logic [WORD_BYTES*8-1:0]            wr_data_i,
  input  logic [2:0]                         wr_off_i,
  input  logic [3:0]                         wr_len_i,
  input  logic [$clog2(DEPTH_BYTES)-1:0]     rd_ptr_i,
  output logic [MAX_INSTR_BYTES*8-1:0]       window_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH_BYTES);

  byte_t mem_q    [DEPTH_BYTES];
  byte_t wr_bytes [WORD_BYTES];

  // Split the little-endian memory word into byte lanes.
  always_comb begin
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      wr_bytes[i] = wr_data_i[8*i +: 8];
    end
  end

  // Store word bytes wr_off.. into consecutive ring slots from wr_ptr.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH_BYTES; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      for (int unsigned i = 0; i < WORD_BYTES; i++) begin
        if (i < 32'(wr_len_i)) begin
          mem_q[wr_ptr_i + PTR_W'(i)] <= wr_bytes[wr_off_i + 3'(i)];
        end
      end
    end
  end

  // Window starting at the read pointer, wrapping around the ring.
  always_comb begin
    for (int unsigned i = 0; i < MAX_INSTR_BYTES; i++) begin
      window_o[8*i +: 8] = mem_q[rd_ptr_i + PTR_W'(i)];
    end
  end

endmodule

// File: rtl/imem_prefetch.sv
// Y86-64 instruction prefetch queue: fetches aligned 8-byte words ahead of
// the fetch stage, presents a 10-byte window at the current PC and flushes
// on redirect.
module imem_prefetch
  import y86_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 16,
  parameter int unsigned ADDR_W      = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               redirect,
  input  logic [ADDR_W-1:0]                  redirect_pc,
  imem_prefetch_if.master                    mem,
  output logic [MAX_INSTR_BYTES*8-1:0]       win_bytes,
  output logic [ADDR_W-1:0]                  win_pc,
  output logic [$clog2(DEPTH_BYTES):0]       win_avail,
  input  logic                               consume,
  input  logic [3:0]                         consume_len,
  output logic                               imem_error
);

  localparam int unsigned PTR_W = $clog2(DEPTH_BYTES);
  localparam int unsigned CNT_W = PTR_W + 1;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:3], 3'b000};
  endfunction

  pf_state_t          state_q, state_d;
  logic [ADDR_W-1:0]  fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0]  win_pc_q, win_pc_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               err_q, err_d;

  logic               consume_ok;
  logic               append;
  logic [3:0]         append_len;

  // Only the first word after a redirect can start mid-word.
  assign append_len = 4'(WORD_BYTES) - {1'b0, fetch_addr_q[2:0]};

  assign consume_ok = consume && !redirect && (consume_len != 4'd0) &&
                      (CNT_W'(consume_len) <= count_q);

  assign append     = !redirect && (state_q == REQ) && mem.mem_ack && !mem.mem_err;

  // Next-state, pointer, count and fetch-address computation.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    mem_addr_d   = mem_addr_q;
    win_pc_d     = win_pc_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    err_d        = err_q;

    if (redirect) begin
      count_d      = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      win_pc_d     = redirect_pc;
      fetch_addr_d = redirect_pc;
      err_d        = 1'b0;
      // With no request in flight the new fetch issues on this same edge.
      unique case (state_q)
        REQ, DROP: state_d = mem.mem_ack ? IDLE : DROP;
        default: begin
          state_d    = REQ;
          mem_addr_d = word_align(redirect_pc);
        end
      endcase
    end else begin
      if (consume_ok) begin
        win_pc_d = win_pc_q + ADDR_W'(consume_len);
        rd_ptr_d = rd_ptr_q + PTR_W'(consume_len);
      end
      if (append) begin
        wr_ptr_d     = wr_ptr_q + PTR_W'(append_len);
        fetch_addr_d = word_align(fetch_addr_q) + ADDR_W'(WORD_BYTES);
      end
      count_d = count_q
              - (consume_ok ? CNT_W'(consume_len) : '0)
              + (append     ? CNT_W'(append_len)  : '0);

      case (state_q)
        IDLE: begin
          if (count_q <= CNT_W'(DEPTH_BYTES - WORD_BYTES)) begin
            state_d    = REQ;
            mem_addr_d = word_align(fetch_addr_q);
          end
        end
        REQ: begin
          if (mem.mem_ack) begin
            if (mem.mem_err) begin
              state_d = ERR;
              err_d   = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DROP: begin
          if (mem.mem_ack) begin
            state_d = IDLE;
          end
        end
        ERR:     state_d = ERR;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      mem_addr_q   <= '0;
      win_pc_q     <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      mem_addr_q   <= mem_addr_d;
      win_pc_q     <= win_pc_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

  pf_byte_ring #(
    .DEPTH_BYTES (DEPTH_BYTES)
  ) u_ring (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (append),
    .wr_ptr_i  (wr_ptr_q),
    .wr_data_i (mem.mem_rdata),
    .wr_off_i  (fetch_addr_q[2:0]),
    .wr_len_i  (append_len),
    .rd_ptr_i  (rd_ptr_q),
    .window_o  (win_bytes)
  );

  assign mem.mem_req  = (state_q == REQ) || (state_q == DROP);
  assign mem.mem_addr = mem_addr_q;
  assign win_pc       = win_pc_q;
  assign win_avail    = count_q;
  assign imem_error   = err_q;

endmodule
